// File: rtl/instr_stream_seq_if.sv
// Instruction stream channel from the sequencer to the core: one beat per
// cycle when out_valid and out_ready are both high.
interface instr_stream_seq_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
);
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (output out_valid, output out_instr, output out_pc, input out_ready);
  modport slave  (input out_valid, input out_instr, input out_pc, output out_ready);
endinterface

// File: rtl/instr_stream_seq.sv
// Loadable instruction store that streams {instr, pc} beats to a core, with
// wrap/one-shot sequencing, PC redirect, a beat budget and halt.
module instr_stream_seq #(
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int WRAP_EN = 1,
  parameter int BEAT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_we,
  input  logic [DATA_W-1:0] load_data,
  input  logic              load_clear,
  input  logic              start,
  input  logic              halt,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic [BEAT_W-1:0] max_beats,
  instr_stream_seq_if.master stream,
  output logic [ADDR_W:0]   count,
  output logic              running,
  output logic              done,
  output logic              load_ovf,
  output logic              bad_redirect
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] store [DEPTH];

  state_t            state_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] instr_reg;
  logic              valid_reg;
  logic [BEAT_W-1:0] beats_reg;
  logic [BEAT_W-1:0] budget_reg;
  logic              ovf_reg;
  logic              bad_reg;

  logic              accept;
  logic [BEAT_W-1:0] beats_next;
  logic              budget_hit;
  logic              last_pc;
  logic              redirect_bad;
  logic              can_start;
  logic              store_we;
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] rd_data;

  assign accept       = valid_reg & stream.out_ready;
  assign beats_next   = beats_reg + 1'b1;
  assign budget_hit   = accept && (budget_reg != '0) && (beats_next == budget_reg);
  assign last_pc      = ({1'b0, pc_reg} == (count_reg - 1'b1));
  assign redirect_bad = ({1'b0, redirect_pc} >= count_reg);
  assign can_start    = start && (state_reg != RUN) && (count_reg != '0);
  assign store_we     = (state_reg == IDLE) && !load_clear && load_we && (count_reg != DEPTH_C);

  // Address of the beat that will be presented after this edge; the store
  // is read combinationally so the output register captures it directly.
  always_comb begin
    pc_next = pc_reg;
    if (state_reg == RUN && redirect_valid) begin
      pc_next = redirect_pc;
    end else if (can_start) begin
      pc_next = '0;
    end else if (accept) begin
      pc_next = last_pc ? '0 : pc_reg + 1'b1;
    end
  end

  assign rd_data = store[pc_next];

  always_ff @(posedge clk) begin
    if (store_we) begin
      store[count_reg[ADDR_W-1:0]] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      pc_reg     <= '0;
      instr_reg  <= '0;
      valid_reg  <= 1'b0;
      beats_reg  <= '0;
      budget_reg <= '0;
      ovf_reg    <= 1'b0;
      bad_reg    <= 1'b0;
    end else begin
      if (state_reg == IDLE) begin
        if (load_clear) begin
          count_reg <= '0;
          ovf_reg   <= 1'b0;
          bad_reg   <= 1'b0;
        end else if (load_we) begin
          if (count_reg == DEPTH_C) begin
            ovf_reg <= 1'b1;
          end else begin
            count_reg <= count_reg + 1'b1;
          end
        end
      end

      if (halt) begin
        state_reg <= IDLE;
        valid_reg <= 1'b0;
      end else if (state_reg == RUN && redirect_valid) begin
        // A beat taken this cycle still counts; a budget stop beats the jump.
        if (accept) begin
          beats_reg <= beats_next;
        end
        if (budget_hit) begin
          state_reg <= DONE;
          valid_reg <= 1'b0;
        end else if (redirect_bad) begin
          bad_reg   <= 1'b1;
          state_reg <= DONE;
          valid_reg <= 1'b0;
        end else begin
          pc_reg    <= pc_next;
          instr_reg <= rd_data;
          valid_reg <= 1'b1;
        end
      end else if (can_start) begin
        state_reg  <= RUN;
        pc_reg     <= '0;
        beats_reg  <= '0;
        budget_reg <= max_beats;
        instr_reg  <= rd_data;
        valid_reg  <= 1'b1;
      end else if (state_reg == RUN && accept) begin
        beats_reg <= beats_next;
        if (budget_hit || (last_pc && WRAP_EN == 0)) begin
          state_reg <= DONE;
          valid_reg <= 1'b0;
        end else begin
          pc_reg    <= pc_next;
          instr_reg <= rd_data;
        end
      end
    end
  end

  assign stream.out_valid = valid_reg;
  assign stream.out_instr = instr_reg;
  assign stream.out_pc    = pc_reg;
  assign count            = count_reg;
  assign running          = (state_reg == RUN);
  assign done             = (state_reg == DONE);
  assign load_ovf         = ovf_reg;
  assign bad_redirect     = bad_reg;
endmodule

// File: tb/tb_instr_stream_seq.sv
// Drives a wrapping and a one-shot sequencer with identical stimulus and
// checks both against a per-cycle behavioural model plus literal expectations.
module tb_instr_stream_seq;
  localparam int DW = 32;
  localparam int DP = 256;
  localparam int AW = 8;
  localparam int BW = 16;
  localparam int S_IDLE = 0;
  localparam int S_RUN  = 1;
  localparam int S_DONE = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          load_we, load_clear, start, halt, redirect_valid, out_ready;
  logic [DW-1:0] load_data;
  logic [AW-1:0] redirect_pc;
  logic [BW-1:0] max_beats;

  logic [1:0][AW:0]   cnt_o;
  logic [1:0]         run_o, done_o, ovf_o, bad_o, vo;
  logic [1:0][AW-1:0] po;
  logic [1:0][DW-1:0] io;

  int errors = 0;
  int checks = 0;

  instr_stream_seq_if #(.DATA_W(DW), .ADDR_W(AW)) ifa ();
  instr_stream_seq_if #(.DATA_W(DW), .ADDR_W(AW)) ifb ();

  assign ifa.out_ready = out_ready;
  assign ifb.out_ready = out_ready;
  assign vo = {ifb.out_valid, ifa.out_valid};
  assign po = {ifb.out_pc, ifa.out_pc};
  assign io = {ifb.out_instr, ifa.out_instr};

  instr_stream_seq #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .WRAP_EN(1), .BEAT_W(BW)) dut_a (
    .clk(clk), .rst(rst), .load_we(load_we), .load_data(load_data), .load_clear(load_clear),
    .start(start), .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .max_beats(max_beats), .stream(ifa), .count(cnt_o[0]), .running(run_o[0]), .done(done_o[0]),
    .load_ovf(ovf_o[0]), .bad_redirect(bad_o[0]));

  instr_stream_seq #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW), .WRAP_EN(0), .BEAT_W(BW)) dut_b (
    .clk(clk), .rst(rst), .load_we(load_we), .load_data(load_data), .load_clear(load_clear),
    .start(start), .halt(halt), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .max_beats(max_beats), .stream(ifb), .count(cnt_o[1]), .running(run_o[1]), .done(done_o[1]),
    .load_ovf(ovf_o[1]), .bad_redirect(bad_o[1]));

  always #5 clk = ~clk;

  // Behavioural model, index 0 = wrapping instance, 1 = one-shot instance.
  int          m_st [2];
  int          m_cnt [2];
  int          m_pc [2];
  int          m_beats [2];
  int          m_bud [2];
  bit          m_ov [2];
  bit          m_ovf [2];
  bit          m_bad [2];
  logic [DW-1:0] m_mem [2][DP];

  int acc0 [$];
  int acc1 [$];

  task automatic chk(input string name, input int k, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        m_st[k] = S_IDLE; m_cnt[k] = 0; m_pc[k] = 0; m_beats[k] = 0;
        m_bud[k] = 0; m_ov[k] = 0; m_ovf[k] = 0; m_bad[k] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit acc;
        bit hit;
        int oc;
        int ost;
        oc  = m_cnt[k];
        ost = m_st[k];
        acc = m_ov[k] && out_ready;
        hit = 0;
        if (ost == S_IDLE) begin
          if (load_clear) begin
            m_cnt[k] = 0; m_ovf[k] = 0; m_bad[k] = 0;
          end else if (load_we) begin
            if (oc == DP) m_ovf[k] = 1;
            else begin
              m_mem[k][oc] = load_data;
              m_cnt[k] = oc + 1;
            end
          end
        end
        if (acc) begin
          m_beats[k] = m_beats[k] + 1;
          hit = (m_bud[k] != 0) && (m_beats[k] == m_bud[k]);
        end
        if (halt) begin
          m_st[k] = S_IDLE; m_ov[k] = 0;
        end else if (ost == S_RUN && redirect_valid) begin
          if (hit) begin
            m_st[k] = S_DONE; m_ov[k] = 0;
          end else if (int'(redirect_pc) >= oc) begin
            m_bad[k] = 1; m_st[k] = S_DONE; m_ov[k] = 0;
          end else begin
            m_pc[k] = int'(redirect_pc); m_ov[k] = 1;
          end
        end else if (start && ost != S_RUN && oc > 0) begin
          m_st[k] = S_RUN; m_pc[k] = 0; m_beats[k] = 0;
          m_bud[k] = int'(max_beats); m_ov[k] = 1;
        end else if (ost == S_RUN && acc) begin
          if (hit) begin
            m_st[k] = S_DONE; m_ov[k] = 0;
          end else if (m_pc[k] == oc - 1) begin
            if (k == 0) m_pc[k] = 0;
            else begin
              m_st[k] = S_DONE; m_ov[k] = 0;
            end
          end else begin
            m_pc[k] = m_pc[k] + 1;
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      chk("running", k, run_o[k], m_st[k] == S_RUN);
      chk("done", k, done_o[k], m_st[k] == S_DONE);
      chk("count", k, cnt_o[k], m_cnt[k]);
      chk("load_ovf", k, ovf_o[k], m_ovf[k]);
      chk("bad_redirect", k, bad_o[k], m_bad[k]);
      chk("out_valid", k, vo[k], m_ov[k]);
      if (m_ov[k]) begin
        chk("out_pc", k, po[k], m_pc[k]);
        chk("out_instr", k, io[k], m_mem[k][m_pc[k]]);
      end
      if (vo[k] && out_ready) begin
        $display("beat dut%0d pc=%0d instr=%08h", k, po[k], io[k]);
        if (k == 0) acc0.push_back(int'(po[k]));
        else        acc1.push_back(int'(po[k]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_seq(input string name, input int k, input int expv[$]);
    int got[$];
    got = (k == 0) ? acc0 : acc1;
    chk({name, "_len"}, k, got.size(), expv.size());
    for (int i = 0; i < expv.size() && i < got.size(); i++) chk(name, k, got[i], expv[i]);
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_halt();
    halt = 1'b1;
    tick();
    halt = 1'b0;
    acc0.delete();
    acc1.delete();
  endtask

  initial begin
    int e[$];
    rst = 1'b1; load_we = 0; load_clear = 0; start = 0; halt = 0;
    redirect_valid = 0; out_ready = 0; load_data = '0; redirect_pc = '0; max_beats = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 0, vo[0], 0);
    chk("rst_count", 0, cnt_o[0], 0);
    chk("rst_pc", 0, po[0], 0);
    chk("rst_instr", 0, io[0], 0);

    // Load three instructions.
    load_we = 1;
    load_data = 32'h11111111; tick();
    load_data = 32'h22222222; tick();
    load_data = 32'h33333333; tick();
    load_we = 0;
    chk("load_count", 0, cnt_o[0], 3);

    // Budget of 7 with wrap; one-shot instance stops after pc 2.
    max_beats = 16'd7; out_ready = 1;
    do_start();
    chk("first_valid", 0, vo[0], 1);
    chk("first_pc", 0, po[0], 0);
    repeat (9) tick();
    e = {0, 1, 2, 0, 1, 2, 0}; chk_seq("budget_seq", 0, e);
    e = {0, 1, 2};             chk_seq("oneshot_seq", 1, e);
    chk("budget_done", 0, done_o[0], 1);
    chk("budget_valid", 0, vo[0], 0);
    acc0.delete(); acc1.delete();

    // Unlimited budget: one-shot stops, wrapping instance keeps going.
    max_beats = 16'd0;
    do_start();
    repeat (6) tick();
    e = {0, 1, 2}; chk_seq("nowrap_seq", 1, e);
    chk("nowrap_done", 1, done_o[1], 1);
    chk("wrap_running", 0, run_o[0], 1);
    do_halt();
    chk("halt_idle", 0, run_o[0] | done_o[0], 0);

    // Stall pattern 1,0,0,1.
    out_ready = 0;
    do_start();
    chk("stall_first_pc", 0, po[0], 0);
    out_ready = 1; tick();
    out_ready = 0; tick();
    chk("stall_pc_a", 0, po[0], 1);
    tick();
    chk("stall_pc_b", 0, po[0], 1);
    chk("stall_instr", 0, io[0], 32'h22222222);
    out_ready = 1; tick();
    out_ready = 0;
    e = {0, 1}; chk_seq("stall_seq", 0, e);
    chk("stall_pc_after", 0, po[0], 2);
    do_halt();

    // Redirect drops the unaccepted pc 0 beat, then a bad redirect.
    do_start();
    redirect_valid = 1; redirect_pc = 8'd1; tick();
    redirect_valid = 0;
    chk("redir_pc", 0, po[0], 1);
    chk("redir_instr", 0, io[0], 32'h22222222);
    out_ready = 1; tick();
    out_ready = 0;
    e = {1}; chk_seq("redir_seq", 0, e);
    redirect_valid = 1; redirect_pc = 8'd5; tick();
    redirect_valid = 0;
    chk("bad_redir_flag", 0, bad_o[0], 1);
    chk("bad_redir_done", 0, done_o[0], 1);
    chk("bad_redir_valid", 0, vo[0], 0);
    do_halt();

    // halt outranks redirect and start.
    do_start();
    chk("pre_halt_run", 0, run_o[0], 1);
    halt = 1; redirect_valid = 1; redirect_pc = 8'd1; start = 1; tick();
    halt = 0; redirect_valid = 0; start = 0;
    chk("halt_prio_run", 0, run_o[0], 0);
    chk("halt_prio_done", 0, done_o[0], 0);
    chk("halt_prio_valid", 0, vo[0], 0);
    acc0.delete(); acc1.delete();

    // Asynchronous reset mid-stream.
    out_ready = 1;
    do_start();
    tick();
    chk("pre_rst_valid", 0, vo[0], 1);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", 0, vo[0], 0);
    chk("async_rst_count", 0, cnt_o[0], 0);
    chk("async_rst_run", 0, run_o[0], 0);
    out_ready = 0;
    tick();
    rst = 0;
    acc0.delete(); acc1.delete();

    // Fill the store, overflow once, then clear.
    load_we = 1;
    for (int i = 0; i < DP; i++) begin
      load_data = 32'hA0000000 + i;
      tick();
    end
    load_data = 32'hDEADBEEF; tick();
    load_we = 0;
    chk("full_count", 0, cnt_o[0], 256);
    chk("ovf_flag", 0, ovf_o[0], 1);
    do_start();
    chk("ovf_store0", 0, io[0], 32'hA0000000);
    do_halt();
    load_clear = 1; tick();
    load_clear = 0;
    chk("clear_count", 0, cnt_o[0], 0);
    chk("clear_ovf", 0, ovf_o[0], 0);
    do_start();
    chk("empty_start", 0, run_o[0], 0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
